// File: rtl/parity_pkg.sv
// Shared types and constants for the serial even-parity link: FSM states,
// default widths and the parity helper used by both the checker and link models.
package parity_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Even parity of a zero-extended vector: 0 means an even number of ones.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive side of the serial even-parity link: deserialises DATA_W bits plus a
// parity bit, flags mismatches, holds the word for a valid/ready handshake.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              data_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clr_status,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  error_count
);

  // The bit counter must reach DATA_W while in PARITY.
  localparam int BC_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              parity_err_q, parity_err_d;
  logic              data_valid_q, data_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_inc, err_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    frame_inc    = 1'b0;
    err_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
      end
      DATA: begin
        if (frame_start) begin
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end else if (bit_valid) begin
          shift_d   = {shift_q[DATA_W-2:0], bit_in};
          par_d     = par_q ^ bit_in;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (frame_start) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end else if (bit_valid) begin
          state_d      = HOLD;
          data_out_d   = shift_q;
          parity_err_d = par_q ^ bit_in;
          data_valid_d = 1'b1;
          frame_inc    = 1'b1;
          err_inc      = par_q ^ bit_in;
        end
      end
      HOLD: begin
        // A frame_start coinciding with the handshake starts the next frame cleanly.
        if (data_valid_q && out_ready) begin
          data_valid_d = 1'b0;
          if (frame_start) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (frame_start) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_status) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_inc),
    .clr   (clr_status),
    .count (frame_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clr_status),
    .count (error_count)
  );

  assign data_out   = data_out_q;
  assign parity_err = parity_err_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: a directed vector table, hand-written corner
// sequences and random traffic, all scored against a frame-level reference model.
module tb_serial_parity_checker;
  import parity_pkg::*;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst, frame_start, bit_in, bit_valid, out_ready, clr_status;

  logic [DW-1:0] d8_data, d2_data;
  logic          d8_err, d2_err, d8_valid, d2_valid, d8_ovr, d2_ovr;
  logic [7:0]    d8_fc, d8_ec;
  logic [1:0]    d2_fc, d2_ec;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DW), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .data_out(d8_data), .parity_err(d8_err),
    .data_valid(d8_valid), .out_ready(out_ready), .overrun(d8_ovr),
    .clr_status(clr_status), .frame_count(d8_fc), .error_count(d8_ec)
  );

  serial_parity_checker #(.DATA_W(DW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .data_out(d2_data), .parity_err(d2_err),
    .data_valid(d2_valid), .out_ready(out_ready), .overrun(d2_ovr),
    .clr_status(clr_status), .frame_count(d2_fc), .error_count(d2_ec)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the link (collected bits, pending word).
  bit            m_in_frame, m_pending, m_err, m_ovr;
  logic [DW-1:0] m_word;
  bit            m_bits[$];
  int            m_frames, m_errors;

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input logic fs, input logic b, input logic bv,
                            input logic rdy, input logic clr, input logic r);
    logic [DW-1:0] w;
    if (r) begin
      m_in_frame = 0; m_pending = 0; m_err = 0; m_ovr = 0;
      m_word = '0; m_bits.delete(); m_frames = 0; m_errors = 0;
      return;
    end
    if (m_pending) begin
      if (rdy) begin
        m_pending = 0;
        if (fs) begin m_in_frame = 1; m_bits.delete(); end
      end else if (fs) begin
        m_ovr = 1;
      end
    end else if (m_in_frame) begin
      if (fs) begin
        m_bits.delete();
      end else if (bv) begin
        if (m_bits.size() < DW) begin
          m_bits.push_back(b);
        end else begin
          w = '0;
          foreach (m_bits[i]) w = {w[DW-2:0], m_bits[i]};
          m_word = w;
          m_err = even_parity(32'({w, b}));
          m_pending = 1;
          m_in_frame = 0;
          m_frames++;
          m_errors += int'(m_err);
        end
      end
    end else if (fs) begin
      m_in_frame = 1;
      m_bits.delete();
    end
    if (clr) begin
      m_ovr = 0; m_frames = 0; m_errors = 0;
    end
  endtask

  task automatic compare_all();
    check("mdl_valid8", 32'(d8_valid), 32'(m_pending));
    check("mdl_data8",  32'(d8_data),  32'(m_word));
    check("mdl_err8",   32'(d8_err),   32'(m_err));
    check("mdl_ovr8",   32'(d8_ovr),   32'(m_ovr));
    check("mdl_fc8",    32'(d8_fc),    32'(sat(m_frames, 8)));
    check("mdl_ec8",    32'(d8_ec),    32'(sat(m_errors, 8)));
    check("mdl_valid2", 32'(d2_valid), 32'(m_pending));
    check("mdl_fc2",    32'(d2_fc),    32'(sat(m_frames, 2)));
    check("mdl_ec2",    32'(d2_ec),    32'(sat(m_errors, 2)));
  endtask

  // One clock: inputs are applied after the previous edge, outputs sampled 1 unit after this edge.
  task automatic cycle(input logic fs, input logic b, input logic bv,
                       input logic rdy, input logic clr, input logic r);
    frame_start = fs; bit_in = b; bit_valid = bv;
    out_ready = rdy; clr_status = clr; rst = r;
    @(posedge clk);
    model_step(fs, b, bv, rdy, clr, r);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic p, input bit with_fs);
    if (with_fs) cycle(1, 0, 0, 1, 0, 0);
    for (int i = DW - 1; i >= 0; i--) cycle(0, w[i], 1, 1, 0, 0);
    cycle(0, p, 1, 0, 0, 0);
  endtask

  task automatic clear_stats();
    cycle(0, 0, 0, 0, 1, 0);
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic          par;
    int            stall;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b1011, 1'b1, 0, 4'b1011, 1'b0};
    vecs[1] = '{4'b0000, 1'b1, 0, 4'b0000, 1'b1};
    vecs[2] = '{4'b0110, 1'b0, 3, 4'b0110, 1'b0};
    vecs[3] = '{4'b1110, 1'b1, 1, 4'b1110, 1'b0};
    vecs[4] = '{4'b1000, 1'b1, 0, 4'b1000, 1'b0};
    vecs[5] = '{4'b1111, 1'b1, 2, 4'b1111, 1'b1};

    frame_start = 0; bit_in = 0; bit_valid = 0; out_ready = 0; clr_status = 0; rst = 1;
    model_step(0, 0, 0, 0, 0, 1);

    // Reset state
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("rst_valid", 32'(d8_valid), 0);
    check("rst_data",  32'(d8_data),  0);
    check("rst_err",   32'(d8_err),   0);
    check("rst_ovr",   32'(d8_ovr),   0);
    check("rst_fc",    32'(d8_fc),    0);
    check("rst_ec",    32'(d8_ec),    0);
    // bit_valid with no frame_start is ignored
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    check("idle_ignore_valid", 32'(d8_valid), 0);

    // Table-driven frames with back-pressure
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].word, vecs[v].par, 1);
      check("tbl_valid", 32'(d8_valid), 1);
      check("tbl_data",  32'(d8_data),  32'(vecs[v].exp_data));
      check("tbl_err",   32'(d8_err),   32'(vecs[v].exp_err));
      for (int s = 0; s < vecs[v].stall; s++) begin
        cycle(0, 0, 0, 0, 0, 0);
        check("tbl_hold_valid", 32'(d8_valid), 1);
        check("tbl_hold_data",  32'(d8_data),  32'(vecs[v].exp_data));
      end
      cycle(0, 0, 0, 1, 0, 0);
      check("tbl_release", 32'(d8_valid), 0);
      if (v == 0) begin
        check("first_fc", 32'(d8_fc), 1);
        check("first_ec", 32'(d8_ec), 0);
      end
      if (v == 1) check("bad_ec", 32'(d8_ec), 1);
    end

    // Sweep every word with the generator's parity bit
    clear_stats();
    for (int w = 0; w < 16; w++) begin
      send_frame(DW'(w), even_parity(32'(w)), 1);
      check("sweep_data", 32'(d8_data), 32'(w));
      check("sweep_err",  32'(d8_err),  0);
      cycle(0, 0, 0, 1, 0, 0);
    end
    check("sweep_fc", 32'(d8_fc), 16);
    check("sweep_ec", 32'(d8_ec), 0);

    // Overrun during hold, then clr_status
    clear_stats();
    send_frame(4'b0110, 1'b0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    check("ovr_set",   32'(d8_ovr),   1);
    check("ovr_valid", 32'(d8_valid), 1);
    check("ovr_data",  32'(d8_data),  32'(4'b0110));
    check("ovr_fc",    32'(d8_fc),    1);
    cycle(0, 0, 0, 1, 0, 0);
    check("ovr_release", 32'(d8_valid), 0);
    cycle(0, 1, 1, 0, 0, 0);
    clear_stats();
    check("clr_ovr", 32'(d8_ovr), 0);
    check("clr_fc",  32'(d8_fc),  0);
    check("clr_ec",  32'(d8_ec),  0);

    // frame_start coinciding with the handshake goes straight to DATA
    send_frame(4'b1011, 1'b1, 1);
    cycle(1, 0, 0, 1, 0, 0);
    check("hs_fs_valid", 32'(d8_valid), 0);
    check("hs_fs_ovr",   32'(d8_ovr),   0);
    send_frame(4'b0101, 1'b0, 0);
    check("hs_fs_data", 32'(d8_data), 32'(4'b0101));
    check("hs_fs_err",  32'(d8_err),  0);
    cycle(0, 0, 0, 1, 0, 0);

    // Resync discards the partial frame
    clear_stats();
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    send_frame(4'b1110, 1'b1, 1);
    check("resync_data", 32'(d8_data), 32'(4'b1110));
    check("resync_err",  32'(d8_err),  0);
    check("resync_fc",   32'(d8_fc),   1);
    cycle(0, 0, 0, 1, 0, 0);

    // Saturation
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      send_frame(4'b0000, 1'b1, 1);
      cycle(0, 0, 0, 1, 0, 0);
    end
    check("sat_fc2", 32'(d2_fc), 3);
    check("sat_ec2", 32'(d2_ec), 3);
    check("sat_fc8", 32'(d8_fc), 5);
    check("sat_ec8", 32'(d8_ec), 5);

    // clr_status beats a same-cycle increment
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < DW; i++) cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 1, 0);
    check("clr_win_valid", 32'(d8_valid), 1);
    check("clr_win_fc",    32'(d8_fc),    0);
    check("clr_win_ec",    32'(d8_ec),    0);
    cycle(0, 0, 0, 1, 0, 0);

    // Reset mid-frame
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 1);
    check("rstmid_fc", 32'(d8_fc), 0);
    send_frame(4'b1000, 1'b1, 1);
    check("rstmid_data", 32'(d8_data), 32'(4'b1000));
    check("rstmid_err",  32'(d8_err),  0);
    check("rstmid_fc1",  32'(d8_fc),   1);
    cycle(0, 0, 0, 1, 0, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(11) == 0), 1'($urandom), ($urandom_range(1) == 1),
            ($urandom_range(2) != 0), ($urandom_range(63) == 0),
            ($urandom_range(499) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
